// File: rtl/pulpino_mailbox.sv
// pulpino_mailbox: host <-> processor mailbox built from two circular FIFOs
// with a toggle-handshake GPIO presenter (H2P) and capture port (P2H).
`default_nettype none

module pulpino_mailbox #(
  parameter int pDATA_WIDTH = 8,
  parameter int pDEPTH      = 16,
  parameter int pPTR_WIDTH  = 4
) (
  input  logic                   crypto_clk,
  input  logic                   reset_i,
  input  logic                   I_wr_en,
  input  logic [pDATA_WIDTH-1:0] I_wr_data,
  input  logic                   I_rd_en,
  output logic [pDATA_WIDTH-1:0] O_rd_data,
  input  logic                   I_clear_err,
  output logic [pPTR_WIDTH:0]    O_h2p_count,
  output logic [pPTR_WIDTH:0]    O_p2h_count,
  output logic                   O_h2p_full,
  output logic                   O_p2h_empty,
  output logic                   O_overflow,
  output logic                   O_underflow,
  output logic [pDATA_WIDTH-1:0] O_h2p_data,
  output logic                   O_h2p_tgl,
  input  logic                   I_h2p_ack_tgl,
  input  logic [pDATA_WIDTH-1:0] I_p2h_data,
  input  logic                   I_p2h_tgl,
  output logic                   O_p2h_ack_tgl
);

  localparam logic [pPTR_WIDTH:0]   FULL_COUNT = (pPTR_WIDTH+1)'(pDEPTH);
  localparam logic [pPTR_WIDTH-1:0] PTR_ONE    = 1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } pres_state_t;

  logic [pDATA_WIDTH-1:0] h2p_mem [pDEPTH];
  logic [pDATA_WIDTH-1:0] p2h_mem [pDEPTH];

  logic [pPTR_WIDTH-1:0] h2p_wr_ptr, h2p_rd_ptr;
  logic [pPTR_WIDTH-1:0] p2h_wr_ptr, p2h_rd_ptr;
  logic [pPTR_WIDTH:0]   h2p_count, p2h_count;
  logic [pDATA_WIDTH-1:0] h2p_data, rd_data;
  logic                   h2p_tgl, p2h_ack_tgl;
  logic                   overflow, underflow;

  logic        h2p_full, h2p_empty, p2h_full, p2h_empty;
  logic        h2p_push, h2p_pop, p2h_push, p2h_pop;
  logic        wr_err, rd_err;
  pres_state_t pres_state;
  logic [pPTR_WIDTH-1:0] p2h_head_nxt;
  logic [pPTR_WIDTH:0]   p2h_avail;

  // The presenter state is the toggle relation itself, so an ack held high
  // through reset naturally keeps the presenter waiting.
  assign pres_state = (h2p_tgl == I_h2p_ack_tgl) ? ST_IDLE : ST_WAIT_ACK;

  assign h2p_full  = (h2p_count == FULL_COUNT);
  assign h2p_empty = (h2p_count == '0);
  assign p2h_full  = (p2h_count == FULL_COUNT);
  assign p2h_empty = (p2h_count == '0);

  assign h2p_push = I_wr_en & ~h2p_full;
  assign h2p_pop  = (pres_state == ST_IDLE) & ~h2p_empty;
  assign p2h_push = (I_p2h_tgl != p2h_ack_tgl) & ~p2h_full;
  assign p2h_pop  = I_rd_en & ~p2h_empty;
  assign wr_err   = I_wr_en & h2p_full;
  assign rd_err   = I_rd_en & p2h_empty;

  // Words left in P2H once this cycle's pop is taken, before any push.
  assign p2h_avail    = p2h_count - {{pPTR_WIDTH{1'b0}}, p2h_pop};
  assign p2h_head_nxt = p2h_pop ? (p2h_rd_ptr + PTR_ONE) : p2h_rd_ptr;

  always_ff @(posedge crypto_clk) begin
    if (h2p_push) h2p_mem[h2p_wr_ptr] <= I_wr_data;
    if (p2h_push) p2h_mem[p2h_wr_ptr] <= I_p2h_data;
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      h2p_wr_ptr  <= '0;
      h2p_rd_ptr  <= '0;
      h2p_count   <= '0;
      p2h_wr_ptr  <= '0;
      p2h_rd_ptr  <= '0;
      p2h_count   <= '0;
      h2p_data    <= '0;
      rd_data     <= '0;
      h2p_tgl     <= 1'b0;
      p2h_ack_tgl <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (h2p_push) h2p_wr_ptr <= h2p_wr_ptr + PTR_ONE;
      if (h2p_pop) begin
        h2p_rd_ptr <= h2p_rd_ptr + PTR_ONE;
        h2p_data   <= h2p_mem[h2p_rd_ptr];
        h2p_tgl    <= ~h2p_tgl;
      end
      h2p_count <= h2p_count + {{pPTR_WIDTH{1'b0}}, h2p_push}
                             - {{pPTR_WIDTH{1'b0}}, h2p_pop};

      if (p2h_push) begin
        p2h_wr_ptr  <= p2h_wr_ptr + PTR_ONE;
        p2h_ack_tgl <= ~p2h_ack_tgl;
      end
      if (p2h_pop) p2h_rd_ptr <= p2h_head_nxt;
      p2h_count <= p2h_count + {{pPTR_WIDTH{1'b0}}, p2h_push}
                             - {{pPTR_WIDTH{1'b0}}, p2h_pop};

      // First-word-fall-through head: a word pushed into an otherwise empty
      // FIFO bypasses memory; an emptied FIFO keeps showing its last word.
      if (p2h_push && (p2h_avail == '0))
        rd_data <= I_p2h_data;
      else if (p2h_avail != '0)
        rd_data <= p2h_mem[p2h_head_nxt];

      overflow  <= (overflow  & ~I_clear_err) | wr_err;
      underflow <= (underflow & ~I_clear_err) | rd_err;
    end
  end

  assign O_rd_data     = rd_data;
  assign O_h2p_count   = h2p_count;
  assign O_p2h_count   = p2h_count;
  assign O_h2p_full    = h2p_full;
  assign O_p2h_empty   = p2h_empty;
  assign O_overflow    = overflow;
  assign O_underflow   = underflow;
  assign O_h2p_data    = h2p_data;
  assign O_h2p_tgl     = h2p_tgl;
  assign O_p2h_ack_tgl = p2h_ack_tgl;

endmodule

`default_nettype wire

// File: tb/tb_pulpino_mailbox.sv
// tb_pulpino_mailbox: directed self-checking bench for pulpino_mailbox
// (pDATA_WIDTH=8, pDEPTH=4).
`default_nettype none

module tb_pulpino_mailbox;

  logic       crypto_clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       I_wr_en = 1'b0;
  logic [7:0] I_wr_data = '0;
  logic       I_rd_en = 1'b0;
  logic [7:0] O_rd_data;
  logic       I_clear_err = 1'b0;
  logic [2:0] O_h2p_count, O_p2h_count;
  logic       O_h2p_full, O_p2h_empty, O_overflow, O_underflow;
  logic [7:0] O_h2p_data;
  logic       O_h2p_tgl;
  logic       I_h2p_ack_tgl = 1'b0;
  logic [7:0] I_p2h_data = '0;
  logic       I_p2h_tgl = 1'b0;
  logic       O_p2h_ack_tgl;

  int total = 0;
  int bad = 0;

  always #5 crypto_clk = ~crypto_clk;

  pulpino_mailbox #(
    .pDATA_WIDTH(8),
    .pDEPTH(4),
    .pPTR_WIDTH(2)
  ) dut (
    .crypto_clk   (crypto_clk),
    .reset_i      (reset_i),
    .I_wr_en      (I_wr_en),
    .I_wr_data    (I_wr_data),
    .I_rd_en      (I_rd_en),
    .O_rd_data    (O_rd_data),
    .I_clear_err  (I_clear_err),
    .O_h2p_count  (O_h2p_count),
    .O_p2h_count  (O_p2h_count),
    .O_h2p_full   (O_h2p_full),
    .O_p2h_empty  (O_p2h_empty),
    .O_overflow   (O_overflow),
    .O_underflow  (O_underflow),
    .O_h2p_data   (O_h2p_data),
    .O_h2p_tgl    (O_h2p_tgl),
    .I_h2p_ack_tgl(I_h2p_ack_tgl),
    .I_p2h_data   (I_p2h_data),
    .I_p2h_tgl    (I_p2h_tgl),
    .O_p2h_ack_tgl(O_p2h_ack_tgl)
  );

  // Advance one rising edge, then settle before checking or driving.
  task automatic step();
    @(posedge crypto_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    step();
    step();
    check("rst_h2p_count", 32'(O_h2p_count), 0);
    check("rst_p2h_count", 32'(O_p2h_count), 0);
    check("rst_full",      32'(O_h2p_full), 0);
    check("rst_empty",     32'(O_p2h_empty), 1);
    check("rst_tgl",       32'(O_h2p_tgl), 0);
    check("rst_ack",       32'(O_p2h_ack_tgl), 0);
    check("rst_h2p_data",  32'(O_h2p_data), 0);
    check("rst_rd_data",   32'(O_rd_data), 0);
    check("rst_flags",     32'({O_overflow, O_underflow}), 0);
    reset_i = 1'b0;
    step();

    // Single word, processor idle
    I_wr_en = 1'b1; I_wr_data = 8'hA5;
    step();
    I_wr_en = 1'b0;
    check("a5_count_after_E", 32'(O_h2p_count), 1);
    step();
    check("a5_data", 32'(O_h2p_data), 32'hA5);
    check("a5_tgl",  32'(O_h2p_tgl), 1);
    check("a5_count", 32'(O_h2p_count), 0);
    I_h2p_ack_tgl = 1'b1;
    step();
    step();
    check("a5_idle_tgl", 32'(O_h2p_tgl), 1);
    check("a5_idle_data", 32'(O_h2p_data), 32'hA5);

    // Fill H2P with no acks, then overflow
    for (int k = 1; k <= 5; k++) begin
      I_wr_en = 1'b1; I_wr_data = 8'(k);
      step();
    end
    check("fill_count", 32'(O_h2p_count), 4);
    check("fill_full",  32'(O_h2p_full), 1);
    check("fill_data",  32'(O_h2p_data), 1);
    check("fill_tgl",   32'(O_h2p_tgl), 0);
    check("fill_ovf0",  32'(O_overflow), 0);
    I_wr_data = 8'h06;
    step();
    I_wr_en = 1'b0;
    check("ovf_set",   32'(O_overflow), 1);
    check("ovf_count", 32'(O_h2p_count), 4);
    for (int k = 2; k <= 5; k++) begin
      I_h2p_ack_tgl = ~I_h2p_ack_tgl;
      step();
      step();
      check("order_data",  32'(O_h2p_data), 32'(k));
      check("order_count", 32'(O_h2p_count), 32'(5 - k));
    end
    I_h2p_ack_tgl = ~I_h2p_ack_tgl;
    I_clear_err = 1'b1;
    step();
    I_clear_err = 1'b0;
    check("ovf_cleared", 32'(O_overflow), 0);
    check("h2p_idle", 32'(O_h2p_tgl == I_h2p_ack_tgl), 1);

    // Single P2H word
    I_p2h_data = 8'h3C; I_p2h_tgl = 1'b1;
    step();
    check("p2h_ack",   32'(O_p2h_ack_tgl), 1);
    check("p2h_count", 32'(O_p2h_count), 1);
    check("p2h_rd",    32'(O_rd_data), 32'h3C);
    check("p2h_nempty", 32'(O_p2h_empty), 0);
    I_rd_en = 1'b1;
    step();
    I_rd_en = 1'b0;
    check("p2h_pop_empty", 32'(O_p2h_empty), 1);
    check("p2h_pop_count", 32'(O_p2h_count), 0);
    check("p2h_pop_hold",  32'(O_rd_data), 32'h3C);

    // P2H backpressure
    for (int k = 0; k < 4; k++) begin
      I_p2h_data = 8'h10 + 8'(k); I_p2h_tgl = ~I_p2h_tgl;
      step();
    end
    check("bp_count4", 32'(O_p2h_count), 4);
    check("bp_head",   32'(O_rd_data), 32'h10);
    check("bp_ack4",   32'(O_p2h_ack_tgl), 1);
    I_p2h_data = 8'h14; I_p2h_tgl = ~I_p2h_tgl;
    step();
    step();
    check("bp_ack_held", 32'(O_p2h_ack_tgl), 1);
    check("bp_count_held", 32'(O_p2h_count), 4);
    check("bp_no_err", 32'(O_underflow), 0);
    I_rd_en = 1'b1;
    step();
    I_rd_en = 1'b0;
    check("bp_pop_head",  32'(O_rd_data), 32'h11);
    check("bp_pop_count", 32'(O_p2h_count), 3);
    check("bp_pop_ack",   32'(O_p2h_ack_tgl), 1);
    step();
    check("bp_cap_ack",   32'(O_p2h_ack_tgl), 0);
    check("bp_cap_count", 32'(O_p2h_count), 4);
    for (int k = 0; k < 4; k++) begin
      check("drain_head", 32'(O_rd_data), 32'h11 + 32'(k));
      I_rd_en = 1'b1;
      step();
      I_rd_en = 1'b0;
    end
    check("drain_empty", 32'(O_p2h_empty), 1);
    check("drain_hold",  32'(O_rd_data), 32'h14);

    // Underflow and clear priority
    I_rd_en = 1'b1;
    step();
    I_rd_en = 1'b0;
    check("unf_set",   32'(O_underflow), 1);
    check("unf_count", 32'(O_p2h_count), 0);
    I_rd_en = 1'b1; I_clear_err = 1'b1;
    step();
    I_rd_en = 1'b0;
    check("unf_priority", 32'(O_underflow), 1);
    step();
    I_clear_err = 1'b0;
    check("unf_cleared", 32'(O_underflow), 0);

    // Reset mid-transfer; a high p2h toggle through reset is a pending word
    for (int k = 0; k < 3; k++) begin
      I_wr_en = 1'b1; I_wr_data = 8'h21 + 8'(k);
      step();
    end
    I_wr_en = 1'b0;
    I_p2h_data = 8'h55; I_p2h_tgl = 1'b1;
    step();
    check("pre_rst_ack", 32'(O_p2h_ack_tgl), 1);
    check("pre_rst_tgl", 32'(O_h2p_tgl), 1);
    reset_i = 1'b1; I_h2p_ack_tgl = 1'b0;
    step();
    check("mid_rst_h2p_count", 32'(O_h2p_count), 0);
    check("mid_rst_p2h_count", 32'(O_p2h_count), 0);
    check("mid_rst_toggles", 32'({O_h2p_tgl, O_p2h_ack_tgl}), 0);
    check("mid_rst_h2p_data", 32'(O_h2p_data), 0);
    check("mid_rst_rd_data", 32'(O_rd_data), 0);
    reset_i = 1'b0;
    step();
    check("post_rst_capture", 32'(O_p2h_count), 1);
    check("post_rst_ack", 32'(O_p2h_ack_tgl), 1);
    check("post_rst_rd", 32'(O_rd_data), 32'h55);
    I_wr_en = 1'b1; I_wr_data = 8'h77;
    step();
    I_wr_en = 1'b0;
    step();
    check("post_rst_first", 32'(O_h2p_data), 32'h77);
    check("post_rst_tgl",   32'(O_h2p_tgl), 1);
    check("post_rst_h2p_count", 32'(O_h2p_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulpino_mailbox.md
PULPINO_MAILBOX -- requirements
Module: pulpino_mailbox

Interface
REQ-001 The block SHALL have these parameters:
- pDATA_WIDTH, default 8: channel word width.
- pDEPTH, default 16: entries per FIFO; power of two, at least 2.
- pPTR_WIDTH, default 4: log2(pDEPTH).
REQ-002 The block SHALL use one clock, crypto_clk; the reset is reset_i, synchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- crypto_clk, in, 1: clock.
- reset_i, in, 1: synchronous active-high reset.
- I_wr_en, in, 1: host push into the host-to-processor (H2P) FIFO.
- I_wr_data, in, pDATA_WIDTH: host push word.
- I_rd_en, in, 1: host pop from the processor-to-host (P2H) FIFO.
- O_rd_data, out, pDATA_WIDTH: P2H head word, first-word-fall-through.
- I_clear_err, in, 1: clears the sticky error flags.
- O_h2p_count, out, pPTR_WIDTH+1: H2P occupancy.
- O_p2h_count, out, pPTR_WIDTH+1: P2H occupancy.
- O_h2p_full, out, 1: H2P FIFO full.
- O_p2h_empty, out, 1: P2H FIFO empty.
- O_overflow, out, 1: sticky, a host write was dropped.
- O_underflow, out, 1: sticky, a host read hit an empty FIFO.
- O_h2p_data, out, pDATA_WIDTH: word presented to the processor GPIO inputs.
- O_h2p_tgl, out, 1: toggles when a new word is presented.
- I_h2p_ack_tgl, in, 1: processor toggles this after consuming a word.
- I_p2h_data, in, pDATA_WIDTH: processor GPIO output word.
- I_p2h_tgl, in, 1: processor toggles this when I_p2h_data is valid.
- O_p2h_ack_tgl, out, 1: block toggles this when a word is captured.

Function
REQ-004 All processor-side inputs SHALL be synchronous to crypto_clk; the block SHALL NOT contain a synchronizer.
REQ-005 Each FIFO SHALL be a circular buffer with pPTR_WIDTH-bit pointers that wrap from pDEPTH-1 to 0, and an occupancy count of width pPTR_WIDTH+1.
REQ-006 Full SHALL mean count==pDEPTH and empty SHALL mean count==0; both SHALL be evaluated from registered state before the current edge.
REQ-007 A host write when H2P is not full SHALL be stored at edge E, and O_h2p_count SHALL increment after E.
REQ-008 A host write when H2P is full SHALL be dropped and SHALL set O_overflow, even if an H2P pop occurs in the same cycle.
REQ-009 A host read when P2H is not empty SHALL advance the P2H head at edge E; O_rd_data SHALL show the next word, or hold the last value if the FIFO becomes empty.
REQ-010 A host read when P2H is empty SHALL leave all state unchanged and SHALL set O_underflow.
REQ-011 The H2P presenter SHALL use two states:
- IDLE: O_h2p_tgl==I_h2p_ack_tgl.
- WAIT_ACK: the two differ.
REQ-012 In IDLE with H2P not empty, the block SHALL at the next edge load the head word into O_h2p_data, pop H2P, and invert O_h2p_tgl.
REQ-013 O_h2p_data SHALL hold its value until the next presentation.
REQ-014 The H2P pipeline SHALL behave as follows:
- A write accepted at edge E into an empty, IDLE H2P SHALL appear on O_h2p_data/O_h2p_tgl at edge E+1.
- A following word SHALL be presented no earlier than one edge after the ack toggle is sampled.
REQ-015 P2H capture SHALL be defined by the relation of I_p2h_tgl to O_p2h_ack_tgl:
- When they differ and P2H is not full: push I_p2h_data and invert O_p2h_ack_tgl at the same edge.
- When P2H is full: do not capture and do not toggle the ack (backpressure); this is not an error.
REQ-016 Simultaneous push and pop on one FIFO SHALL leave its count unchanged and SHALL be legal at any occupancy except as limited by REQ-008 and REQ-010.
REQ-017 Simultaneous P2H capture and host read on an empty P2H SHALL be treated as an underflow; the captured word SHALL remain stored.
REQ-018 I_clear_err SHALL clear both sticky flags; an error occurring in the same cycle SHALL take priority and the flag SHALL stay set.

Reset
REQ-019 Reset SHALL force, at the next edge and regardless of any other input:
- pointers and counts to 0.
- O_h2p_data and O_rd_data to 0.
- O_h2p_tgl and O_p2h_ack_tgl to 0.
- O_overflow and O_underflow to 0.
- O_h2p_full to 0 and O_p2h_empty to 1.
- presenter state to IDLE.
REQ-020 Reset in the middle of a transfer SHALL discard all queued and in-flight words.
REQ-021 After reset, I_p2h_tgl==1 SHALL be treated as a pending word; I_h2p_ack_tgl==1 SHALL hold the presenter in WAIT_ACK until the ack returns to 0.

Verification
REQ-022 The bench SHALL cover these directed scenarios (pDATA_WIDTH=8, pDEPTH=4):
- Write 0xA5 at edge E with the processor idle -> at E+1, O_h2p_data=0xA5, O_h2p_tgl=1 and O_h2p_count=0; toggle I_h2p_ack_tgl -> IDLE.
- Write 0x01..0x05 with no processor acks -> 0x01 presented; 0x02..0x05 queued with count=4 and full=1; then write 0x06 -> dropped, O_overflow=1, and later delivery order 0x02..0x05.
- Processor toggles I_p2h_tgl with 0x3C -> O_p2h_ack_tgl=1, O_p2h_count=1 and O_rd_data=0x3C next cycle; I_rd_en -> empty, count=0.
- Four P2H words then a fifth toggle with no host reads -> fifth not acked, ack_tgl unchanged; one I_rd_en -> fifth captured on the next edge.
- I_rd_en on empty -> O_underflow=1; I_clear_err together with another empty read -> stays 1; I_clear_err alone -> 0.
- Queue 3 words, assert reset_i for one cycle -> all counts 0, toggles 0, O_h2p_data=0; the next write is presented first.
